// File: rtl/theremin_gen_pkg.sv
// Shared definitions for the period signal generator: FSM state encoding and
// the width of the optional fractional period field.
package theremin_gen_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HIGH = 2'd1,
        LOW  = 2'd2
    } gen_state_e;

    localparam int FRAC_BITS = 4;

endpackage : theremin_gen_pkg

// File: rtl/halfperiod_counter.sv
// Phase down-counter: loads a cycle count, decrements while enabled and
// saturates at zero; terminal count is flagged while the count is zero.
module halfperiod_counter #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             ce,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    output logic             tc
);

    logic [WIDTH-1:0] count;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values of the others, independent of block order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (ce) begin
            if (load) begin
                count <= load_value;
            end else if (count != '0) begin
                count <= count - WIDTH'(1);
            end
        end
    end

    assign tc = (count == '0);

endmodule : halfperiod_counter

// File: rtl/period_signal_generator.sv
// Square-wave generator with a glitch-free period update at rising edges.
// Optional fractional period (F/16 dithering of the LOW phase): PERIOD_GEN_FRAC_EN.
module period_signal_generator
    import theremin_gen_pkg::*;
#(
    parameter int PERIOD_BITS = 16
) (
    input  logic CLK,
    input  logic RESET_N,
    input  logic CE,
`ifdef PERIOD_GEN_FRAC_EN
    input  logic [PERIOD_BITS+FRAC_BITS-1:0] PERIOD_IN,
`else
    input  logic [PERIOD_BITS-1:0]           PERIOD_IN,
`endif
    input  logic LOAD,
    output logic LOAD_ACK,
    output logic FREQ_OUT,
    output logic PERIOD_START,
    output logic RUNNING
);

    localparam int IN_W = $bits(PERIOD_IN);

    gen_state_e            state;
    logic [IN_W-1:0]       pending;
    logic                  load_flag;
    logic [PERIOD_BITS-1:0] active;
    logic [PERIOD_BITS-1:0] pend_int;
    logic [PERIOD_BITS-1:0] next_p;
    logic [PERIOD_BITS-1:0] low_value;
    logic                  tc;
    logic                  cnt_load;
    logic [PERIOD_BITS-1:0] cnt_value;
    logic                  boundary;
    logic                  stop;

    assign pend_int = pending[IN_W-1 -: PERIOD_BITS];
    // A one-cycle period cannot hold both phases, so it is widened to two.
    assign next_p   = (pend_int == PERIOD_BITS'(1)) ? PERIOD_BITS'(2) : pend_int;

`ifdef PERIOD_GEN_FRAC_EN
    logic [FRAC_BITS-1:0] pend_frac;
    logic [FRAC_BITS-1:0] acc;
    logic [FRAC_BITS:0]   acc_sum;
    logic                 extend;

    assign pend_frac = pending[FRAC_BITS-1:0];
    assign acc_sum   = {1'b0, acc} + {1'b0, pend_frac};
    assign low_value = active - (active >> 1) - PERIOD_BITS'(1) + PERIOD_BITS'(extend);
`else
    assign low_value = active - (active >> 1) - PERIOD_BITS'(1);
`endif

    // NOTE: every signal driven here gets a default first; a path that leaves
    // one unassigned would infer a latch.
    always_comb begin
        cnt_load  = 1'b0;
        cnt_value = '0;
        boundary  = 1'b0;
        stop      = 1'b0;
        unique case (state)
            IDLE: boundary = (pend_int != '0);
            HIGH: begin
                if (tc) begin
                    cnt_load  = 1'b1;
                    cnt_value = low_value;
                end
            end
            LOW: begin
                if (tc) begin
                    if (pend_int == '0) stop = 1'b1;
                    else                boundary = 1'b1;
                end
            end
            default: ;
        endcase
        if (boundary) begin
            cnt_load  = 1'b1;
            cnt_value = (next_p >> 1) - PERIOD_BITS'(1);
        end
    end

    halfperiod_counter #(
        .WIDTH(PERIOD_BITS)
    ) u_counter (
        .clk       (CLK),
        .rst_n     (RESET_N),
        .ce        (CE),
        .load      (cnt_load),
        .load_value(cnt_value),
        .tc        (tc)
    );

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state        <= IDLE;
            pending      <= '0;
            load_flag    <= 1'b0;
            active       <= '0;
            FREQ_OUT     <= 1'b0;
            LOAD_ACK     <= 1'b0;
            PERIOD_START <= 1'b0;
`ifdef PERIOD_GEN_FRAC_EN
            acc          <= '0;
            extend       <= 1'b0;
`endif
        end else if (!CE) begin
            // Pulses are dropped rather than held so a stall cannot repeat them.
            LOAD_ACK     <= 1'b0;
            PERIOD_START <= 1'b0;
        end else begin
            LOAD_ACK     <= 1'b0;
            PERIOD_START <= 1'b0;
            if (LOAD) pending <= PERIOD_IN;
            if (LOAD)                  load_flag <= 1'b1;
            else if (boundary || stop) load_flag <= 1'b0;

            if (boundary) begin
                state        <= HIGH;
                FREQ_OUT     <= 1'b1;
                PERIOD_START <= 1'b1;
                LOAD_ACK     <= load_flag;
                active       <= next_p;
`ifdef PERIOD_GEN_FRAC_EN
                acc          <= acc_sum[FRAC_BITS-1:0];
                extend       <= acc_sum[FRAC_BITS];
`endif
            end else if (stop) begin
                state    <= IDLE;
                FREQ_OUT <= 1'b0;
                active   <= '0;
            end else if (state == HIGH && tc) begin
                state    <= LOW;
                FREQ_OUT <= 1'b0;
            end
        end
    end

    assign RUNNING = (state != IDLE);

endmodule : period_signal_generator

// File: tb/tb_period_signal_generator.sv
// Directed bench for period_signal_generator: a per-cycle positional model plus
// hand-computed phase lengths. Fraction tests run when PERIOD_GEN_FRAC_EN is set.
module tb_period_signal_generator;

    localparam int PB = 16;
`ifdef PERIOD_GEN_FRAC_EN
    localparam int FB = 4;
`else
    localparam int FB = 0;
`endif
    localparam int IW = PB + FB;

    logic          CLK = 1'b0;
    logic          RESET_N = 1'b0;
    logic          CE = 1'b0;
    logic          LOAD = 1'b0;
    logic [IW-1:0] PERIOD_IN = '0;
    logic          LOAD_ACK, FREQ_OUT, PERIOD_START, RUNNING;

    int total = 0;
    int bad = 0;
    bit chk_en = 1'b0;
    int ack_cnt = 0;

    period_signal_generator #(
        .PERIOD_BITS(PB)
    ) dut (
        .CLK         (CLK),
        .RESET_N     (RESET_N),
        .CE          (CE),
        .PERIOD_IN   (PERIOD_IN),
        .LOAD        (LOAD),
        .LOAD_ACK    (LOAD_ACK),
        .FREQ_OUT    (FREQ_OUT),
        .PERIOD_START(PERIOD_START),
        .RUNNING     (RUNNING)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int int_part(input logic [IW-1:0] v);
        return int'(v >> FB);
    endfunction

    function automatic int frac_part(input logic [IW-1:0] v);
`ifdef PERIOD_GEN_FRAC_EN
        return int'(v[3:0]);
`else
        return 0;
`endif
    endfunction

    // Model: position inside the current period; the wave is high for the
    // first per/2 positions, and the period ends after len positions.
    int            m_per = 0, m_pos = 0, m_len = 0, m_acc = 0;
    bit            m_run = 0, m_flag = 0, m_start = 0, m_ack = 0;
    logic [IW-1:0] m_pend = '0;

    always @(posedge CLK or negedge RESET_N) begin : model
        int per, pos, len, acc;
        bit run, flag, st, ak, bnd;
        if (!RESET_N) begin
            m_per <= 0; m_pos <= 0; m_len <= 0; m_acc <= 0;
            m_run <= 0; m_flag <= 0; m_start <= 0; m_ack <= 0; m_pend <= '0;
        end else if (!CE) begin
            m_start <= 0;
            m_ack   <= 0;
        end else begin
            per = m_per; pos = m_pos; len = m_len; acc = m_acc;
            run = m_run; flag = m_flag; st = 0; ak = 0; bnd = 0;
            if (run) begin
                pos++;
                if (pos == len) begin
                    if (int_part(m_pend) == 0) begin
                        run = 0; flag = 0; pos = 0; per = 0; len = 0;
                    end else begin
                        bnd = 1;
                    end
                end
            end else if (int_part(m_pend) != 0) begin
                bnd = 1;
            end
            if (bnd) begin
                per  = (int_part(m_pend) == 1) ? 2 : int_part(m_pend);
                len  = per;
                pos  = 0;
                run  = 1;
                st   = 1;
                ak   = flag;
                flag = 0;
                acc  = acc + frac_part(m_pend);
                if (acc >= 16) begin
                    acc = acc - 16;
                    len = len + 1;
                end
            end
            if (LOAD) flag = 1;
            m_per <= per; m_pos <= pos; m_len <= len; m_acc <= acc;
            m_run <= run; m_flag <= flag; m_start <= st; m_ack <= ak;
            if (LOAD) m_pend <= PERIOD_IN;
        end
    end

    always @(negedge CLK) begin
        if (LOAD_ACK === 1'b1) ack_cnt++;
        if (chk_en) begin
            check("freq_out",     FREQ_OUT,     (m_run && m_pos < m_per / 2));
            check("period_start", PERIOD_START, m_start);
            check("load_ack",     LOAD_ACK,     m_ack);
            check("running",      RUNNING,      m_run);
        end
    end

    task automatic load_val(input int p, input int f);
`ifdef PERIOD_GEN_FRAC_EN
        PERIOD_IN = IW'((p << FB) | (f & 15));
`else
        PERIOD_IN = IW'(p + (f * 0));
`endif
        LOAD = 1'b1;
        @(negedge CLK);
        LOAD = 1'b0;
    endtask

    task automatic wait_start();
        bit ok = 0;
        for (int i = 0; i < 200 && !ok; i++) begin
            @(negedge CLK);
            if (PERIOD_START === 1'b1) ok = 1;
        end
        if (!ok) check("start_timeout", 0, 1);
    endtask

    // Called on the sample where a period begins; returns on the next start
    // sample, or on the first idle sample after a stop.
    task automatic measure(output int hi, output int lo);
        hi = 0;
        lo = 0;
        while (FREQ_OUT === 1'b1 && hi < 300) begin
            hi++;
            @(negedge CLK);
        end
        while (FREQ_OUT === 1'b0 && RUNNING === 1'b1 && lo < 300) begin
            lo++;
            @(negedge CLK);
        end
    endtask

    task automatic expect_period(input string name, input int eh, input int el);
        int h, l;
        measure(h, l);
        check({name, "_high"}, h, eh);
        check({name, "_low"},  l, el);
    endtask

    task automatic reset_pulse();
        #2 RESET_N = 1'b0;
        #1;
        check("rst_freq_out", FREQ_OUT, 0);
        check("rst_running",  RUNNING, 0);
        check("rst_pstart",   PERIOD_START, 0);
        check("rst_ack",      LOAD_ACK, 0);
        repeat (3) @(negedge CLK);
        RESET_N = 1'b1;
        repeat (30) @(negedge CLK);
        check("post_rst_idle_run",  RUNNING, 0);
        check("post_rst_idle_freq", FREQ_OUT, 0);
    endtask

    initial begin
        int h, l, ack_base;
        #1;
        check("init_freq_out", FREQ_OUT, 0);
        check("init_running",  RUNNING, 0);
        check("init_pstart",   PERIOD_START, 0);
        check("init_ack",      LOAD_ACK, 0);
        repeat (3) @(negedge CLK);
        RESET_N = 1'b1;
        CE = 1'b1;
        chk_en = 1'b1;
        repeat (5) @(negedge CLK);

        // P=10: 5 high / 5 low, single acknowledge
        ack_base = ack_cnt;
        load_val(10, 0);
        wait_start();
        check("p10_first_ack", LOAD_ACK, 1);
        for (int i = 0; i < 3; i++) expect_period("p10", 5, 5);
        check("p10_single_ack", ack_cnt - ack_base, 1);

        // P=7 applied at the next boundary: 3 high / 4 low
        fork
            expect_period("p10_before7", 5, 5);
            load_val(7, 0);
        join
        check("p7_ack", LOAD_ACK, 1);
        expect_period("p7a", 3, 4);
        expect_period("p7b", 3, 4);

        // P=1 clamps to 2: 1 high / 1 low
        fork
            expect_period("p7_before1", 3, 4);
            load_val(1, 0);
        join
        expect_period("p1a", 1, 1);
        expect_period("p1b", 1, 1);

        fork
            expect_period("p1_before10", 1, 1);
            load_val(10, 0);
        join
        expect_period("p10_again", 5, 5);

        // LOAD 20 on the second high cycle: current period still 10
        fork
            expect_period("p10_during20", 5, 5);
            begin
                @(negedge CLK);
                load_val(20, 0);
            end
        join
        check("p20_ack", LOAD_ACK, 1);
        check("p20_start", PERIOD_START, 1);
        expect_period("p20", 10, 10);

        // Three stalled cycles during HIGH at P=10 stretch it to 8
        fork
            expect_period("p20_before10", 10, 10);
            load_val(10, 0);
        join
        fork
            expect_period("ce_stall", 8, 5);
            begin
                CE = 1'b0;
                repeat (3) @(negedge CLK);
                CE = 1'b1;
            end
        join

        // LOAD 0: the running period completes, then idle
        fork
            expect_period("p0_last", 5, 5);
            load_val(0, 0);
        join
        check("stop_running", RUNNING, 0);
        check("stop_freq",    FREQ_OUT, 0);
        repeat (20) @(negedge CLK);
        check("stop_stays_idle", RUNNING, 0);

        // Asynchronous reset in the LOW phase, then in the HIGH phase
        load_val(10, 0);
        wait_start();
        repeat (7) @(negedge CLK);
        check("pre_rst_low", FREQ_OUT, 0);
        reset_pulse();
        load_val(10, 0);
        wait_start();
        @(negedge CLK);
        check("pre_rst_high", FREQ_OUT, 1);
        reset_pulse();

`ifdef PERIOD_GEN_FRAC_EN
        // P=10 F=8/16: periods alternate 10, 11; F=0 gives constant 10
        load_val(10, 8);
        wait_start();
        for (int i = 0; i < 2; i++) begin
            expect_period("frac_even", 5, 5);
            expect_period("frac_odd",  5, 6);
        end
        fork
            expect_period("frac_before0", 5, 5);
            load_val(10, 0);
        join
        for (int i = 0; i < 3; i++) expect_period("frac_zero", 5, 5);
`endif

        chk_en = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_period_signal_generator
